// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: byte-strobe writes, read-only status registers,
// per-register write pulses and SLVERR decoding of out-of-range/RO accesses.
//
// state  | meaning
// W_IDLE | collecting AW and W (either order), commit when both are held
// W_RESP | BVALID asserted, waiting for BREADY
// R_IDLE | ARREADY asserted, waiting for AR
// R_RESP | RVALID asserted, RDATA/RRESP held until RREADY
module axi_lite_regbank #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 16,
  parameter int                  ADDR_WIDTH = 6,
  parameter logic [NUM_REGS-1:0] RO_MASK    = {NUM_REGS{1'b0}}
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFFS;
  localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W + 1)'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_RESP } r_state_e;

  w_state_e                w_state_q, w_state_d;
  r_state_e                r_state_q, r_state_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic [IDX_W-1:0]        aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [NUM_REGS-1:0]     pulse_q, pulse_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

  logic                    aw_fire, w_fire, ar_fire;
  logic [IDX_W-1:0]        wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0]   wr_data, rd_val;
  logic [STRB_W-1:0]       wr_strb;
  logic                    wr_in_range, wr_ro, rd_in_range;

  // PROT and the byte-offset address bits carry no meaning for this bank
  logic unused_ok;
  assign unused_ok = ^{AWPROT, ARPROT, AWADDR[OFFS-1:0], ARADDR[OFFS-1:0], status_in};

  assign AWREADY = !ARESET && (w_state_q == W_IDLE) && !aw_held_q;
  assign WREADY  = !ARESET && (w_state_q == W_IDLE) && !w_held_q;
  assign ARREADY = !ARESET && (r_state_q == R_IDLE);
  assign BVALID  = (w_state_q == W_RESP);
  assign RVALID  = (r_state_q == R_RESP);
  assign BRESP   = bresp_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;
  assign reg_wr_pulse = pulse_q;

  assign aw_fire = AWVALID && AWREADY;
  assign w_fire  = WVALID && WREADY;
  assign ar_fire = ARVALID && ARREADY;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_out
    assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[gi] ? '0 : regs_q[gi];
  end

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    pulse_d   = '0;
    regs_d    = regs_q;
    wr_idx    = aw_held_q ? aw_idx_q : AWADDR[ADDR_WIDTH-1:OFFS];
    wr_data   = w_held_q ? wdata_q : WDATA;
    wr_strb   = w_held_q ? wstrb_q : WSTRB;
    wr_in_range = ({1'b0, wr_idx} < NUM_REGS_L);
    wr_ro     = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == IDX_W'(i)) wr_ro = RO_MASK[i];
    end
    case (w_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          aw_idx_d  = AWADDR[ADDR_WIDTH-1:OFFS];
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = WDATA;
          wstrb_d  = WSTRB;
        end
        if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_RESP;
          bresp_d   = (wr_in_range && !wr_ro) ? RESP_OKAY : RESP_SLVERR;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_in_range && !RO_MASK[i] && wr_idx == IDX_W'(i)) begin
              pulse_d[i] = 1'b1;
              for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) regs_d[i][b*8 +: 8] = wr_data[b*8 +: 8];
              end
            end
          end
        end
      end
      W_RESP: begin
        if (BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d   = r_state_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rd_idx      = ARADDR[ADDR_WIDTH-1:OFFS];
    rd_in_range = ({1'b0, rd_idx} < NUM_REGS_L);
    rd_val      = '0;
    // regs_q here is the pre-commit value, so a same-edge write is not visible
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i))
        rd_val = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
    end
    case (r_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          r_state_d = R_RESP;
          rdata_d   = rd_in_range ? rd_val : '0;
          rresp_d   = rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_RESP: begin
        if (RREADY) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      pulse_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      pulse_q   <= pulse_d;
      regs_q    <= regs_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Self-checking bench for axi_lite_regbank: directed scenarios plus randomized
// traffic compared against an array-based register model.
module tb_axi_lite_regbank;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 8;
  localparam logic [NR-1:0] RO = 16'h0080;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic [AW-1:0]   AWADDR, ARADDR;
  logic [2:0]      AWPROT, ARPROT;
  logic            AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic            ARVALID, ARREADY, RVALID, RREADY;
  logic [DW-1:0]   WDATA, RDATA;
  logic [DW/8-1:0] WSTRB;
  logic [1:0]      BRESP, RRESP;
  logic [NR*DW-1:0] reg_out, status_in;
  logic [NR-1:0]   reg_wr_pulse;

  axi_lite_regbank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .RO_MASK(RO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse), .status_in(status_in)
  );

  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] model_regs [NR];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] exp_reg_out();
    logic [NR*DW-1:0] v;
    v = '0;
    for (int k = 0; k < NR; k++) if (!RO[k]) v[k*DW +: DW] = model_regs[k];
    return v;
  endfunction

  function automatic logic writable(input int i);
    if (i >= NR) return 1'b0;
    return !RO[i[3:0]];
  endfunction

  // lead >= 0: W goes first by lead cycles; lead < 0: AW goes first
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, input int lead, input int b_delay);
    int i, cyc, alead;
    bit aw_done, w_done, aw_hs, w_hs;
    logic [1:0] eresp, bseen;
    logic [NR-1:0] epulse;
    i = int'(addr[AW-1:2]);
    alead = (lead < 0) ? -lead : lead;
    epulse = '0;
    eresp = 2'b10;
    if (writable(i)) begin
      eresp = 2'b00;
      epulse[i[3:0]] = 1'b1;
    end
    AWADDR = addr; WDATA = data; WSTRB = strb;
    if (lead >= 0) WVALID = 1'b1;
    if (lead <= 0) AWVALID = 1'b1;
    cyc = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      @(negedge ACLK);
      cyc++;
      if (aw_hs) begin aw_done = 1; AWVALID = 1'b0; end
      if (w_hs)  begin w_done = 1;  WVALID = 1'b0;  end
      if (w_done && !aw_done) check("wready_drop", WREADY, 1'b0);
      if (aw_done && !w_done) check("awready_drop", AWREADY, 1'b0);
      if (cyc == alead) begin
        if (lead > 0 && !aw_done) AWVALID = 1'b1;
        if (lead < 0 && !w_done) WVALID = 1'b1;
      end
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    check("write_handshake_timeout", aw_done && w_done, 1'b1);
    if (!(aw_done && w_done)) return;
    check("bvalid_latency", BVALID, 1'b1);
    check("bresp", BRESP, eresp);
    check("wr_pulse", reg_wr_pulse, epulse);
    if (eresp == 2'b00)
      for (int b = 0; b < 4; b++) if (strb[b]) model_regs[i[3:0]][b*8 +: 8] = data[b*8 +: 8];
    bseen = BRESP;
    for (int k = 0; k < b_delay; k++) begin
      @(negedge ACLK);
      check("b_hold_valid", BVALID, 1'b1);
      check("b_hold_resp", BRESP, bseen);
      check("b_hold_readys", {AWREADY, WREADY}, 2'b00);
      check("pulse_one_cycle", reg_wr_pulse, '0);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    check("b_done", BVALID, 1'b0);
    check("w_readys_back", {AWREADY, WREADY}, 2'b11);
    check("pulse_cleared", reg_wr_pulse, '0);
    check("reg_out", reg_out, exp_reg_out());
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int r_delay);
    int i, cyc;
    bit done;
    logic [DW-1:0] edata, dseen;
    logic [1:0] eresp;
    i = int'(addr[AW-1:2]);
    if (i >= NR) begin
      edata = '0; eresp = 2'b10;
    end else begin
      eresp = 2'b00;
      edata = RO[i[3:0]] ? status_in[i*DW +: DW] : model_regs[i[3:0]];
    end
    ARADDR = addr; ARVALID = 1'b1;
    cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      done = ARREADY;
      @(negedge ACLK);
      cyc++;
    end
    ARVALID = 1'b0;
    check("read_handshake_timeout", done, 1'b1);
    if (!done) return;
    check("rvalid_latency", RVALID, 1'b1);
    check("rdata", RDATA, edata);
    check("rresp", RRESP, eresp);
    dseen = RDATA;
    for (int k = 0; k < r_delay; k++) begin
      @(negedge ACLK);
      check("r_hold_valid", RVALID, 1'b1);
      check("r_hold_data", RDATA, dseen);
      check("r_hold_arready", ARREADY, 1'b0);
    end
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    check("r_done", RVALID, 1'b0);
    check("arready_back", ARREADY, 1'b1);
  endtask

  task automatic scenario_basic();
    for (int k = 0; k < 4; k++) axi_write(AW'(k * 4), DW'(k + 1), 4'hF, 0, 0);
    for (int k = 0; k < 4; k++) axi_read(AW'(k * 4), 0);
    check("basic_reg3", reg_out[3*DW +: DW], 32'h4);
  endtask

  initial begin
    logic [DW-1:0] old_val;
    ARESET = 1'b1;
    AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0;
    AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
    WDATA = '0; WSTRB = '0;
    for (int k = 0; k < NR; k++) begin
      status_in[k*DW +: DW] = $urandom;
      model_regs[k] = '0;
    end
    status_in[7*DW +: DW] = 32'h12345678;

    repeat (20) @(negedge ACLK);
    check("rst_readys_low", {AWREADY, WREADY, ARREADY}, 3'b000);
    check("rst_valids_low", {BVALID, RVALID}, 2'b00);
    ARESET = 1'b0;
    #1;
    check("post_rst_readys", {AWREADY, WREADY, ARREADY}, 3'b111);
    check("post_rst_reg_out", reg_out, '0);
    check("post_rst_pulse", reg_wr_pulse, '0);
    check("post_rst_resp", {BRESP, RRESP, RDATA}, '0);

    scenario_basic();

    axi_write(8'h14, 32'hDEADBEEF, 4'hF, 3, 0);
    check("w_before_aw_slice5", reg_out[5*DW +: DW], 32'hDEADBEEF);
    axi_write(8'h18, 32'hCAFEF00D, 4'hF, -2, 0);

    axi_write(8'h08, 32'h11223344, 4'hF, 0, 0);
    axi_write(8'h08, 32'hAABBCCDD, 4'b0101, 0, 0);
    axi_read(8'h08, 0);
    check("strobe_merge", reg_out[2*DW +: DW], 32'h11BB33DD);
    axi_write(8'h04, 32'hFFFFFFFF, 4'h0, 1, 0);
    check("strb_zero_unchanged", reg_out[1*DW +: DW], 32'h2);

    axi_write(8'h1C, 32'h55555555, 4'hF, 0, 0);
    axi_read(8'h1C, 0);
    check("ro_read_value", RDATA, 32'h12345678);
    axi_write(8'h40, 32'h77777777, 4'hF, 0, 0);
    axi_read(8'h40, 0);
    axi_read(8'h4F, 1);

    axi_write(8'h10, 32'h0BADCAFE, 4'hF, 0, 5);
    axi_read(8'h10, 5);

    // AR and write commit to register 3 at the same edge: read sees the old value
    old_val = model_regs[3];
    AWADDR = 8'h0C; WDATA = 32'h600DD00D; WSTRB = 4'hF; ARADDR = 8'h0C;
    AWVALID = 1; WVALID = 1; ARVALID = 1;
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    check("collision_rdata_old", RDATA, old_val);
    check("collision_valids", {BVALID, RVALID}, 2'b11);
    model_regs[3] = 32'h600DD00D;
    BREADY = 1; RREADY = 1;
    @(negedge ACLK);
    BREADY = 0; RREADY = 0;
    check("collision_reg_out", reg_out, exp_reg_out());

    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      a = AW'(($urandom_range(0, 19) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 2)));
      else
        axi_read(a, int'($urandom_range(0, 2)));
    end

    // reset while both responses are pending
    AWADDR = 8'h00; WDATA = 32'h99; WSTRB = 4'hF; ARADDR = 8'h04;
    AWVALID = 1; WVALID = 1; ARVALID = 1;
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    check("pre_rst_pending", {BVALID, RVALID}, 2'b11);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("mid_rst_valids", {BVALID, RVALID}, 2'b00);
    check("mid_rst_reg_out", reg_out, '0);
    check("mid_rst_pulse", reg_wr_pulse, '0);
    check("mid_rst_readys", {AWREADY, WREADY, ARREADY}, 3'b000);
    ARESET = 1'b0;
    #1;
    check("mid_rst_readys_back", {AWREADY, WREADY, ARREADY}, 3'b111);
    for (int k = 0; k < NR; k++) model_regs[k] = '0;
    scenario_basic();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
